// File: rtl/regfile_write_buffer_if.sv
// Bus bundle for regfile_write_buffer: datapath write-back request, register-file
// write port, forwarding lookups and occupancy.
interface regfile_write_buffer_if #(
  parameter int PTRW = 2
);
  logic          InValid;
  logic          InReady;
  logic [4:0]    InRegister;
  logic [31:0]   InData;
  logic          Hold;
  logic [4:0]    WriteRegister;
  logic [31:0]   WriteData;
  logic          RegWrite;
  logic [4:0]    LookupRegister1;
  logic          LookupHit1;
  logic [31:0]   LookupData1;
  logic [4:0]    LookupRegister2;
  logic          LookupHit2;
  logic [31:0]   LookupData2;
  logic [PTRW:0] Count;

  modport master (
    output InValid, InRegister, InData, Hold, LookupRegister1, LookupRegister2,
    input  InReady, WriteRegister, WriteData, RegWrite,
    input  LookupHit1, LookupData1, LookupHit2, LookupData2, Count
  );

  modport slave (
    input  InValid, InRegister, InData, Hold, LookupRegister1, LookupRegister2,
    output InReady, WriteRegister, WriteData, RegWrite,
    output LookupHit1, LookupData1, LookupHit2, LookupData2, Count
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order write-back buffer in front of the 32x32 register file, with two forwarding
// lookup ports. Define REGFILE_WB_COALESCE_EN to merge writes to an already-queued register.
module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input logic                   Clk,
  input logic                   Reset,
  regfile_write_buffer_if.slave bus
);

  localparam logic [PTRW:0]   CNT_ZERO = {(PTRW+1){1'b0}};
  localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(32'd1);
  localparam logic [PTRW:0]   CNT_FULL = (PTRW+1)'(DEPTH);
  localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(32'd1);

  logic [4:0]      r_reg [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  logic [PTRW:0]   r_count;
  logic [4:0]      r_wr_reg;
  logic [31:0]     r_wr_data;
  logic            r_wr_en;

  logic w_ready;
  logic w_accept;
  logic w_pop;
  logic w_push;
  logic w_coal_hit;

  assign w_ready  = (r_count != CNT_FULL);
  assign w_accept = bus.InValid && w_ready;
  assign w_pop    = (r_count != CNT_ZERO) && !bus.Hold;
  assign w_push   = w_accept && (bus.InRegister != 5'd0) && !w_coal_hit;

`ifdef REGFILE_WB_COALESCE_EN
  logic [PTRW-1:0] w_coal_idx;

  // Youngest queued match; a head leaving this cycle is skipped so the new data is not lost.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = r_rptr;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_accept && (bus.InRegister != 5'd0) && ((PTRW+1)'(k) < r_count) &&
          !(w_pop && (k == 0)) && (r_reg[r_rptr + PTRW'(k)] == bus.InRegister)) begin
        w_coal_hit = 1'b1;
        w_coal_idx = r_rptr + PTRW'(k);
      end else begin
        w_coal_hit = w_coal_hit;
      end
    end
  end
`else
  assign w_coal_hit = 1'b0;
`endif

  // Forwarding search ordered oldest to youngest so the last match wins.
  function automatic logic [32:0] lookup(input logic [4:0] addr);
    logic [32:0] res;
    res = {1'b0, 32'd0};
    if (addr != 5'd0) begin
      if (r_wr_en && (r_wr_reg == addr)) begin
        res = {1'b1, r_wr_data};
      end else begin
        res = res;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (((PTRW+1)'(k) < r_count) && (r_reg[r_rptr + PTRW'(k)] == addr)) begin
          res = {1'b1, r_data[r_rptr + PTRW'(k)]};
        end else begin
          res = res;
        end
      end
    end else begin
      res = res;
    end
    return res;
  endfunction

  assign {bus.LookupHit1, bus.LookupData1} = lookup(bus.LookupRegister1);
  assign {bus.LookupHit2, bus.LookupData2} = lookup(bus.LookupRegister2);

  assign bus.InReady       = w_ready;
  assign bus.Count         = r_count;
  assign bus.RegWrite      = r_wr_en;
  assign bus.WriteRegister = r_wr_reg;
  assign bus.WriteData     = r_wr_data;

  // FIFO storage, pointers, occupancy and the register-file output stage.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_reg[k]  <= 5'd0;
        r_data[k] <= 32'd0;
      end
      r_wptr    <= {PTRW{1'b0}};
      r_rptr    <= {PTRW{1'b0}};
      r_count   <= CNT_ZERO;
      r_wr_reg  <= 5'd0;
      r_wr_data <= 32'd0;
      r_wr_en   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_wr_reg  <= r_reg[r_rptr];
        r_wr_data <= r_data[r_rptr];
        r_wr_en   <= 1'b1;
        r_rptr    <= r_rptr + PTR_ONE;
      end else begin
        r_wr_en <= 1'b0;
      end
      if (w_push) begin
        r_reg[r_wptr]  <= bus.InRegister;
        r_data[r_wptr] <= bus.InData;
        r_wptr         <= r_wptr + PTR_ONE;
      end else begin
        r_wptr <= r_wptr;
      end
`ifdef REGFILE_WB_COALESCE_EN
      if (w_coal_hit) begin
        r_data[w_coal_idx] <= bus.InData;
      end else begin
        r_wptr <= r_wptr + (w_push ? PTR_ONE : {PTRW{1'b0}});
      end
`endif
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Scoreboard bench for regfile_write_buffer: expected writes are queued when requests are
// accepted and compared as RegWrite cycles appear.
module tb_regfile_write_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_write_buffer_if #(.PTRW(2)) bus ();

  regfile_write_buffer #(.DEPTH(4), .PTRW(2)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          errors   = 0;
  int          n_writes = 0;
  logic [4:0]  exp_reg [$];
  logic [31:0] exp_dat [$];
  logic [4:0]  mon_reg;
  logic [31:0] mon_dat;

  // Scoreboard side: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (!rst && bus.RegWrite === 1'b1) begin
      n_writes++;
      checks++;
      if (exp_reg.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got reg %0d data %h want no write",
                 bus.WriteRegister, bus.WriteData);
      end else begin
        mon_reg = exp_reg.pop_front();
        mon_dat = exp_dat.pop_front();
        if (bus.WriteRegister !== mon_reg || bus.WriteData !== mon_dat) begin
          errors++;
          $display("FAIL sb_write got reg %0d data %h want reg %0d data %h",
                   bus.WriteRegister, bus.WriteData, mon_reg, mon_dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [4:0] r, input logic [31:0] d);
    bit merged;
    merged = 1'b0;
    bus.InValid    = 1'b1;
    bus.InRegister = r;
    bus.InData     = d;
    tick();
    bus.InValid = 1'b0;
`ifdef REGFILE_WB_COALESCE_EN
    if (r != 5'd0 && bus.Hold) begin
      for (int i = exp_reg.size() - 1; i >= 0; i--) begin
        if (!merged && exp_reg[i] == r) begin
          exp_dat[i] = d;
          merged = 1'b1;
        end
      end
    end
`endif
    if (r != 5'd0 && !merged) begin
      exp_reg.push_back(r);
      exp_dat.push_back(d);
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      ok = (exp_reg.size() == 0) && (bus.Count == 3'd0) && (bus.RegWrite == 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (bus.Count !== 3'd0 || bus.InReady !== 1'b1 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got count %0d ready %b regwrite %b want 0 1 0",
               bus.Count, bus.InReady, bus.RegWrite);
    end
    checks++;
    if (bus.WriteRegister !== 5'd0 || bus.WriteData !== 32'd0 ||
        bus.LookupHit1 !== 1'b0 || bus.LookupHit2 !== 1'b0 ||
        bus.LookupData1 !== 32'd0 || bus.LookupData2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got wreg %0d wdata %h hits %b%b want all zero",
               bus.WriteRegister, bus.WriteData, bus.LookupHit1, bus.LookupHit2);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.Hold = 1'b0;
    drive_req(5'd5, 32'hDEADBEEF);
    checks++;
    if (bus.Count !== 3'd1 || bus.RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL single_edge1 got count %0d regwrite %b want 1 0", bus.Count, bus.RegWrite);
    end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'd5 ||
        bus.WriteData !== 32'hDEADBEEF || bus.Count !== 3'd0) begin
      errors++;
      $display("FAIL single_edge2 got we %b reg %0d data %h count %0d want 1 5 deadbeef 0",
               bus.RegWrite, bus.WriteRegister, bus.WriteData, bus.Count);
    end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.WriteRegister !== 5'd5 || bus.WriteData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_edge3 got we %b reg %0d data %h want 0 5 deadbeef",
               bus.RegWrite, bus.WriteRegister, bus.WriteData);
    end
  endtask

  task automatic test_zero_reg();
    int n0;
    n0 = n_writes;
    bus.Hold = 1'b0;
    checks++;
    if (bus.InReady !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready got %b want 1", bus.InReady);
    end
    drive_req(5'd0, 32'hFFFFFFFF);
    checks++;
    if (bus.Count !== 3'd0) begin
      errors++;
      $display("FAIL zero_count got %0d want 0", bus.Count);
    end
    repeat (3) tick();
    checks++;
    if (n_writes != n0) begin
      errors++;
      $display("FAIL zero_nowrite got %0d writes want 0", n_writes - n0);
    end
  endtask

  task automatic test_fill_hold();
    bus.Hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_req(5'(i), 32'(i * 17));
      checks++;
      if (bus.Count !== 3'(i)) begin
        errors++;
        $display("FAIL fill_count got %0d want %0d", bus.Count, i);
      end
    end
    checks++;
    if (bus.InReady !== 1'b0) begin
      errors++;
      $display("FAIL fill_ready got %b want 0", bus.InReady);
    end
    bus.InValid = 1'b1;
    bus.InRegister = 5'd6;
    bus.InData = 32'h66;
    tick();
    bus.InValid = 1'b0;
    bus.LookupRegister1 = 5'd3;
    bus.LookupRegister2 = 5'd4;
    #1;
    checks++;
    if (bus.Count !== 3'd4 || bus.LookupHit1 !== 1'b1 || bus.LookupData1 !== 32'h33 ||
        bus.LookupHit2 !== 1'b1 || bus.LookupData2 !== 32'h44) begin
      errors++;
      $display("FAIL fill_full got count %0d hit1 %b d1 %h hit2 %b d2 %h want 4 1 33 1 44",
               bus.Count, bus.LookupHit1, bus.LookupData1, bus.LookupHit2, bus.LookupData2);
    end
    bus.Hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.RegWrite !== 1'b1 || bus.WriteRegister !== 5'(i)) begin
        errors++;
        $display("FAIL fill_drain got we %b reg %0d want 1 %0d", bus.RegWrite, bus.WriteRegister, i);
      end
    end
    tick();
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.Count !== 3'd0) begin
      errors++;
      $display("FAIL fill_idle got we %b count %0d want 0 0", bus.RegWrite, bus.Count);
    end
  endtask

  task automatic test_lookup();
    bit ok;
    bus.Hold = 1'b1;
    drive_req(5'd7, 32'hA);
    drive_req(5'd7, 32'hB);
    bus.LookupRegister1 = 5'd7;
    bus.LookupRegister2 = 5'd0;
    #1;
    checks++;
    if (bus.LookupHit1 !== 1'b1 || bus.LookupData1 !== 32'hB ||
        bus.LookupHit2 !== 1'b0 || bus.LookupData2 !== 32'd0) begin
      errors++;
      $display("FAIL lookup_queued got hit1 %b d1 %h hit2 %b d2 %h want 1 b 0 0",
               bus.LookupHit1, bus.LookupData1, bus.LookupHit2, bus.LookupData2);
    end
    bus.LookupRegister2 = 5'd8;
    #1;
    checks++;
    if (bus.LookupHit2 !== 1'b0 || bus.LookupData2 !== 32'd0) begin
      errors++;
      $display("FAIL lookup_miss got hit %b data %h want 0 0", bus.LookupHit2, bus.LookupData2);
    end
    bus.Hold = 1'b0;
    tick();
    checks++;
    if (bus.LookupHit1 !== 1'b1 || bus.LookupData1 !== 32'hB) begin
      errors++;
      $display("FAIL lookup_young got hit %b data %h want 1 b", bus.LookupHit1, bus.LookupData1);
    end
`ifndef REGFILE_WB_COALESCE_EN
    tick();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.LookupHit1 !== 1'b1 || bus.LookupData1 !== 32'hB) begin
      errors++;
      $display("FAIL lookup_outstage got we %b hit %b data %h want 1 1 b",
               bus.RegWrite, bus.LookupHit1, bus.LookupData1);
    end
`endif
    wait_drain(ok);
    checks++;
    if (!ok || bus.LookupHit1 !== 1'b0 || bus.LookupData1 !== 32'd0) begin
      errors++;
      $display("FAIL lookup_drained got drained %b hit %b data %h want 1 0 0",
               ok, bus.LookupHit1, bus.LookupData1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.Hold = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.InValid    = 1'b1;
      bus.InRegister = 5'(20 + i);
      bus.InData     = 32'h1000 + 32'(i);
      tick();
      exp_reg.push_back(5'(20 + i));
      exp_dat.push_back(32'h1000 + 32'(i));
      checks++;
      if (bus.Count !== 3'd1) begin
        errors++;
        $display("FAIL b2b_count got %0d want 1 at step %0d", bus.Count, i);
      end
    end
    bus.InValid = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain got %0d pending want 0", exp_reg.size());
    end
  endtask

  task automatic test_same_reg();
    bit ok;
    int n0;
    n0 = n_writes;
    bus.Hold = 1'b1;
    drive_req(5'd9, 32'h1);
    drive_req(5'd9, 32'h2);
    checks++;
`ifdef REGFILE_WB_COALESCE_EN
    if (bus.Count !== 3'd1) begin
      errors++;
      $display("FAIL same_count got %0d want 1", bus.Count);
    end
`else
    if (bus.Count !== 3'd2) begin
      errors++;
      $display("FAIL same_count got %0d want 2", bus.Count);
    end
`endif
    bus.Hold = 1'b0;
    wait_drain(ok);
    checks++;
`ifdef REGFILE_WB_COALESCE_EN
    if (!ok || n_writes - n0 != 1) begin
      errors++;
      $display("FAIL same_writes got %0d writes drained %b want 1 1", n_writes - n0, ok);
    end
`else
    if (!ok || n_writes - n0 != 2) begin
      errors++;
      $display("FAIL same_writes got %0d writes drained %b want 2 1", n_writes - n0, ok);
    end
`endif
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.Hold = 1'b1;
    drive_req(5'd10, 32'hA0);
    drive_req(5'd11, 32'hB0);
    drive_req(5'd12, 32'hC0);
    bus.LookupRegister1 = 5'd11;
    bus.LookupRegister2 = 5'd10;
    bus.Hold = 1'b0;
    tick();
    checks++;
    if (bus.RegWrite !== 1'b1 || bus.Count !== 3'd2 || bus.LookupHit2 !== 1'b1 ||
        bus.LookupData2 !== 32'hA0) begin
      errors++;
      $display("FAIL areset_pre got we %b count %0d hit2 %b d2 %h want 1 2 1 a0",
               bus.RegWrite, bus.Count, bus.LookupHit2, bus.LookupData2);
    end
    #1 rst = 1'b1;
    exp_reg.delete();
    exp_dat.delete();
    #1;
    checks++;
    if (bus.RegWrite !== 1'b0 || bus.Count !== 3'd0 || bus.InReady !== 1'b1 ||
        bus.LookupHit1 !== 1'b0 || bus.LookupHit2 !== 1'b0 || bus.WriteRegister !== 5'd0) begin
      errors++;
      $display("FAIL areset_now got we %b count %0d ready %b hits %b%b wreg %0d want 0 0 1 00 0",
               bus.RegWrite, bus.Count, bus.InReady, bus.LookupHit1, bus.LookupHit2,
               bus.WriteRegister);
    end
    tick();
    #1 rst = 1'b0;
    drive_req(5'd13, 32'hD0);
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL areset_after got %0d pending want 0", exp_reg.size());
    end
  endtask

  initial begin
    bus.InValid         = 1'b0;
    bus.InRegister      = 5'd0;
    bus.InData          = 32'd0;
    bus.Hold            = 1'b0;
    bus.LookupRegister1 = 5'd0;
    bus.LookupRegister2 = 5'd0;
    test_reset();
    test_single();
    test_zero_reg();
    test_fill_hold();
    test_lookup();
    test_back_to_back();
    test_same_reg();
    test_async_reset();
    checks++;
    if (exp_reg.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d pending want 0", exp_reg.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
